// File: rtl/shift_pkg.sv
// Shared definitions for the MSB-first shift serializer/deserializer pair.
package shift_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

endpackage

// File: rtl/shift_deser.sv
// Serial-to-parallel deserializer, MSB first, with a one-word holding register.
// Latency: word appears on data_out/out_valid on the edge that samples its last bit.
// Backpressure: none toward the sender; a word completing into an unconsumed register is dropped and flags overrun.
module shift_deser
  import shift_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             shift_enable,
  input  logic             frame_start,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clear_overrun
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] data_nxt;
  logic             valid_nxt;
  logic             overrun_nxt;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             handshake;

  assign shifted   = {sreg[WIDTH-2:0], serial_in};
  assign handshake = out_valid && out_ready;
  assign busy      = (state == RECV);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      data_out  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      sreg      <= sreg_nxt;
      data_out  <= data_nxt;
      out_valid <= valid_nxt;
      overrun   <= overrun_nxt;
    end
  end

  always_comb begin
    cnt_nxt     = cnt;
    sreg_nxt    = sreg;
    data_nxt    = data_out;
    valid_nxt   = out_valid;
    overrun_nxt = overrun;
    complete    = 1'b0;

    // frame_start restarts the word; an accompanying enabled bit becomes bit 1
    if (frame_start) begin
      if (shift_enable) begin
        sreg_nxt = WIDTH'(serial_in);
        cnt_nxt  = CW'(1);
      end else begin
        sreg_nxt = '0;
        cnt_nxt  = '0;
      end
    end else if (shift_enable) begin
      sreg_nxt = shifted;
      if (cnt == CW'(WIDTH - 1)) begin
        cnt_nxt  = '0;
        complete = 1'b1;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end

    state_nxt = (cnt_nxt == '0) ? IDLE : RECV;

    if (clear_overrun) overrun_nxt = 1'b0;

    // A handshake on the completion cycle frees the register for the new word
    if (complete) begin
      if (!out_valid || out_ready) begin
        data_nxt  = shifted;
        valid_nxt = 1'b1;
      end else begin
        overrun_nxt = 1'b1;
      end
    end else if (handshake) begin
      valid_nxt = 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_deser.sv
// Directed self-checking bench for shift_deser at WIDTH=8.
module tb_shift_deser;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       shift_enable;
  logic       frame_start;
  logic [7:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       overrun;
  logic       clear_overrun;

  int checks = 0;
  int errors = 0;

  shift_deser #(.WIDTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .serial_in    (serial_in),
    .shift_enable (shift_enable),
    .frame_start  (frame_start),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .overrun      (overrun),
    .clear_overrun(clear_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bit(input logic b);
    serial_in    = b;
    shift_enable = 1'b1;
    tick();
    shift_enable = 1'b0;
    serial_in    = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) shift_bit(w[i]);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic_word();
    shift_bit(1'b1);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_bit1: got %b expected 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b expected 0", out_valid); end
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0);
    shift_bit(1'b0); shift_bit(1'b1); shift_bit(1'b0); shift_bit(1'b1);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", data_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed_valid: got %b expected 0", out_valid); end
    checks++; if (data_out !== 8'hA5) begin errors++; $display("FAIL basic_hold_data: got %h expected a5", data_out); end
  endtask

  task automatic test_gaps();
    logic [7:0] w;
    w = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      shift_bit(w[i]);
      if (i > 0) begin
        for (int g = 0; g < 3; g++) begin
          tick();
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy bit %0d gap %0d: got %b expected 1", i, g, busy); end
        end
      end
    end
    checks++; if (data_out !== 8'h3C) begin errors++; $display("FAIL gap_data: got %h expected 3c", data_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL gap_valid: got %b expected 1", out_valid); end
    consume();
  endtask

  task automatic test_overrun();
    send_word(8'h11);
    send_word(8'h22);
    checks++; if (data_out !== 8'h11) begin errors++; $display("FAIL ovr_data: got %h expected 11", data_out); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b expected 1", out_valid); end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    consume();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_consumed: got %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'h22;
    send_word(8'h11);
    for (int i = 7; i >= 1; i--) shift_bit(w[i]);
    out_ready = 1'b1;
    shift_bit(w[0]);
    out_ready = 1'b0;
    checks++; if (data_out !== 8'h22) begin errors++; $display("FAIL b2b_data: got %h expected 22", data_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b expected 0", overrun); end
    consume();
  endtask

  task automatic test_frame_start();
    shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1); shift_bit(1'b1);
    frame_start = 1'b1;
    shift_bit(1'b1);
    frame_start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fs_busy: got %b expected 1", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fs_valid: got %b expected 0", out_valid); end
    for (int i = 0; i < 7; i++) shift_bit(1'b0);
    checks++; if (data_out !== 8'h80) begin errors++; $display("FAIL fs_data: got %h expected 80", data_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fs_word_valid: got %b expected 1", out_valid); end
    // A bare frame_start clears the partial word but leaves the holding register alone
    shift_bit(1'b1); shift_bit(1'b0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fs_abort_busy: got %b expected 0", busy); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fs_abort_valid: got %b expected 1", out_valid); end
    checks++; if (data_out !== 8'h80) begin errors++; $display("FAIL fs_abort_data: got %h expected 80", data_out); end
    consume();
  endtask

  task automatic test_reset_mid_word();
    for (int i = 0; i < 5; i++) shift_bit(1'b1);
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", data_out); end
    #1;
    rst = 1'b0;
    send_word(8'hFF);
    checks++; if (data_out !== 8'hFF) begin errors++; $display("FAIL rstmid_word: got %h expected ff", data_out); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid: got %b expected 1", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy_done: got %b expected 0", busy); end
  endtask

  initial begin
    rst           = 1'b1;
    serial_in     = 1'b0;
    shift_enable  = 1'b0;
    frame_start   = 1'b0;
    out_ready     = 1'b0;
    clear_overrun = 1'b0;
    test_reset();
    test_basic_word();
    test_gaps();
    test_overrun();
    test_back_to_back();
    test_frame_start();
    test_reset_mid_word();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
